// File: rtl/dump_pkg.sv
// Shared types and defaults for the DRAM readback (dump) engine.
package dump_pkg;

  localparam int DUMP_ADDR_W     = 9;
  localparam int DUMP_DATA_W     = 16;
  localparam int DUMP_MAX_RD_LAT = 4;
  // Wide enough to count 0 .. DUMP_MAX_RD_LAT-1
  localparam int DUMP_LAT_W      = 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    WAIT = 3'd2,
    SEND = 3'd3,
    DONE = 3'd4
  } dump_state_e;

  function automatic logic state_is_busy(input dump_state_e st);
    return (st != IDLE);
  endfunction

endpackage

// File: rtl/dram_dump_ctrl_if.sv
// Bundles the host start request, DRAM external port and output stream of the dump engine.
interface dram_dump_ctrl_if
  import dump_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W
) ();

  logic              start_dump;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic [ADDR_W-1:0] addr_ext;
  logic              dram_read_ext;
  logic [DATA_W-1:0] dram_out;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;
  logic              busy;
  logic              done;

  // Environment side: host, DRAM and sink
  modport master (
    output start_dump, base_addr, word_count, dram_out, dout_ready,
    input  addr_ext, dram_read_ext, dout, dout_valid, busy, done
  );

  // Dump engine side
  modport slave (
    input  start_dump, base_addr, word_count, dram_out, dout_ready,
    output addr_ext, dram_read_ext, dout, dout_valid, busy, done
  );

endinterface

// File: rtl/dump_addr_gen.sv
// Holds the current dump address and the number of words still to send.
module dump_addr_gen #(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              last
);

  logic [ADDR_W-1:0] cur_addr_r;
  logic [ADDR_W-1:0] remaining_r;

  // Load on start, advance after each accepted word; the address wraps naturally at 2^ADDR_W
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr_r  <= {ADDR_W{1'b0}};
      remaining_r <= {ADDR_W{1'b0}};
    end else if (load) begin
      cur_addr_r  <= base;
      remaining_r <= count;
    end else if (step) begin
      cur_addr_r  <= cur_addr_r + ADDR_W'(1);
      remaining_r <= remaining_r - ADDR_W'(1);
    end else begin
      cur_addr_r  <= cur_addr_r;
      remaining_r <= remaining_r;
    end
  end

  assign cur_addr = cur_addr_r;
  assign last     = (remaining_r == ADDR_W'(1));

endmodule

// File: rtl/dram_dump_ctrl.sv
// Reads a contiguous DRAM range through the external port and streams each word on valid/ready.
module dram_dump_ctrl
  import dump_pkg::*;
#(
  parameter int ADDR_W = DUMP_ADDR_W,
  parameter int DATA_W = DUMP_DATA_W,
  parameter int RD_LAT = 1            // legal 1 .. DUMP_MAX_RD_LAT
) (
  input logic             clock,
  input logic             reset_n,
  dram_dump_ctrl_if.slave bus
);

  localparam logic [DUMP_LAT_W-1:0] LAT_LAST = DUMP_LAT_W'(RD_LAT - 1);

  dump_state_e           state_r;
  dump_state_e           state_nx_s;
  logic [DUMP_LAT_W-1:0] lat_r;
  logic [DUMP_LAT_W-1:0] lat_nx_s;
  logic                  load_s;
  logic                  step_s;
  logic                  capture_s;
  logic                  last_s;
  logic [ADDR_W-1:0]     cur_addr_s;
  logic [DATA_W-1:0]     dout_r;
  logic                  strobe_r;
  logic                  valid_r;
  logic                  busy_r;
  logic                  done_r;

  dump_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (load_s),
    .step     (step_s),
    .base     (bus.base_addr),
    .count    (bus.word_count),
    .cur_addr (cur_addr_s),
    .last     (last_s)
  );

  // Next-state, latency counting and address-generator control
  always_comb begin
    state_nx_s = state_r;
    lat_nx_s   = lat_r;
    load_s     = 1'b0;
    step_s     = 1'b0;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start_dump) begin
          if (bus.word_count != {ADDR_W{1'b0}}) begin
            load_s     = 1'b1;
            state_nx_s = READ;
          end else begin
            state_nx_s = DONE;
          end
        end else begin
          state_nx_s = IDLE;
        end
      end
      READ: begin
        lat_nx_s   = {DUMP_LAT_W{1'b0}};
        state_nx_s = WAIT;
      end
      WAIT: begin
        if (lat_r == LAT_LAST) begin
          capture_s  = 1'b1;
          lat_nx_s   = {DUMP_LAT_W{1'b0}};
          state_nx_s = SEND;
        end else begin
          lat_nx_s   = lat_r + DUMP_LAT_W'(1);
          state_nx_s = WAIT;
        end
      end
      SEND: begin
        if (bus.dout_ready) begin
          step_s     = 1'b1;
          state_nx_s = last_s ? DONE : READ;
        end else begin
          state_nx_s = SEND;
        end
      end
      DONE: begin
        state_nx_s = IDLE;
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
  end

  // State, counter, data capture and outputs decoded one cycle early so they come from flops
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= IDLE;
      lat_r    <= {DUMP_LAT_W{1'b0}};
      dout_r   <= {DATA_W{1'b0}};
      strobe_r <= 1'b0;
      valid_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      lat_r    <= lat_nx_s;
      dout_r   <= capture_s ? bus.dram_out : dout_r;
      strobe_r <= (state_nx_s == READ);
      valid_r  <= (state_nx_s == SEND);
      busy_r   <= state_is_busy(state_nx_s);
      done_r   <= (state_nx_s == DONE);
    end
  end

  assign bus.addr_ext      = cur_addr_s;
  assign bus.dram_read_ext = strobe_r;
  assign bus.dout          = dout_r;
  assign bus.dout_valid    = valid_r;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;

endmodule

// File: tb/tb_dram_dump_ctrl.sv
// Self-checking bench: table-driven dump scenarios, hand sequences and randomized dumps vs a queue model.
module tb_dram_dump_ctrl;

  localparam int AW = 9;
  localparam int DW = 16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dram_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  dram_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  dram_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(b1.slave));
  dram_dump_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus(b3.slave));

  logic          sel   = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base  = '0;
  logic [AW-1:0] cnt   = '0;
  logic          ready = 1'b0;

  assign b1.start_dump = start & ~sel;
  assign b3.start_dump = start & sel;
  assign b1.base_addr  = base;
  assign b3.base_addr  = base;
  assign b1.word_count = cnt;
  assign b3.word_count = cnt;
  assign b1.dout_ready = ready;
  assign b3.dout_ready = ready;

  // DRAM model: data valid exactly RD_LAT cycles after a strobe, poison otherwise
  logic [DW-1:0] mem [512];
  logic [AW-1:0] a1 = '0;
  logic          v1 = 1'b0;
  logic [AW-1:0] a3 [3] = '{9'd0, 9'd0, 9'd0};
  logic          v3 [3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge clock) begin
    a1    <= b1.addr_ext;
    v1    <= b1.dram_read_ext;
    a3[0] <= b3.addr_ext;
    v3[0] <= b3.dram_read_ext;
    for (int k = 1; k < 3; k++) begin
      a3[k] <= a3[k-1];
      v3[k] <= v3[k-1];
    end
  end

  assign b1.dram_out = v1    ? mem[a1]    : 16'hDEAD;
  assign b3.dram_out = v3[2] ? mem[a3[2]] : 16'hDEAD;

  logic          m_strobe, m_valid, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout;

  always_comb begin
    if (sel) begin
      m_strobe = b3.dram_read_ext; m_valid = b3.dout_valid; m_busy = b3.busy;
      m_done   = b3.done;          m_addr  = b3.addr_ext;   m_dout = b3.dout;
    end else begin
      m_strobe = b1.dram_read_ext; m_valid = b1.dout_valid; m_busy = b1.busy;
      m_done   = b1.done;          m_addr  = b1.addr_ext;   m_dout = b1.dout;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: word i of a dump is mem[(base+i) mod 512]; length = 2 + N*(L+2) + stall cycles
  task automatic run_dump(input bit s, input logic [AW-1:0] bs, input logic [AW-1:0] n,
                          input int sw, input int sl, input bit poke, input bit rnd,
                          input int exp_cyc);
    int            lat;
    logic [DW-1:0] got[$];
    logic [AW-1:0] saddr[$];
    int            scyc[$];
    int            vfirst;
    int            cyc;
    int            stalls;
    int            words;
    int            stall_cnt;
    bit            pv;
    bit            pr;
    bit            seen_done;
    bit            poked;
    logic [DW-1:0] pd;
    lat = s ? 3 : 1;
    vfirst = -1; stalls = 0; words = 0; stall_cnt = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; seen_done = 1'b0; poked = 1'b0;
    sel = s; base = bs; cnt = n; start = 1'b1;
    ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    cyc = 1;
    while (!seen_done && cyc < 400) begin
      @(negedge clock);
      cyc++;
      start = 1'b0; base = bs; cnt = n;
      if (m_strobe) begin
        saddr.push_back(m_addr);
        scyc.push_back(cyc);
      end
      if (pv && !pr) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_dout", int'(m_dout), int'(pd));
      end
      if (m_valid && vfirst < 0) vfirst = cyc;
      chk("busy_during_dump", int'(m_busy), 1);
      if (m_done) seen_done = 1'b1;
      if (rnd) ready = 1'($urandom_range(0, 1));
      else if (m_valid && words == sw && stall_cnt < sl) begin
        ready = 1'b0;
        stall_cnt++;
        chk("stall_dout", int'(m_dout), int'(mem[(int'(bs) + words) % 512]));
      end else ready = 1'b1;
      if (poke && m_valid && !poked) begin
        poked = 1'b1; start = 1'b1; base = bs + 9'd100; cnt = 9'd7;
      end
      if (m_valid && !ready) stalls++;
      if (m_valid && ready) begin
        got.push_back(m_dout);
        words++;
      end
      pv = m_valid; pr = ready; pd = m_dout;
    end
    chk("done_seen", int'(seen_done), 1);
    chk("n_words", got.size(), int'(n));
    chk("n_strobes", saddr.size(), int'(n));
    for (int i = 0; i < got.size() && i < int'(n); i++)
      chk("word", int'(got[i]), int'(mem[(int'(bs) + i) % 512]));
    for (int i = 0; i < saddr.size() && i < int'(n); i++)
      chk("strobe_addr", int'(saddr[i]), (int'(bs) + i) % 512);
    if (exp_cyc >= 0) chk("cycles_table", cyc, exp_cyc);
    chk("cycles_model", cyc, 2 + int'(n) * (lat + 2) + stalls);
    if (scyc.size() > 0) chk("first_valid_lat", vfirst - scyc[0], lat + 1);
    if (!rnd && sl == 0)
      for (int i = 1; i < scyc.size(); i++) chk("strobe_period", scyc[i] - scyc[i-1], lat + 2);
    @(negedge clock);
    chk("done_one_cycle", int'(m_done), 0);
    chk("idle_busy", int'(m_busy), 0);
    chk("idle_valid", int'(m_valid), 0);
  endtask

  typedef struct {
    bit            s;
    logic [AW-1:0] bs;
    logic [AW-1:0] n;
    int            sw;
    int            sl;
    bit            poke;
    int            exp_cyc;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int ns;
    int guard;
    for (int i = 0; i < 512; i++) mem[i] = 16'(i * 3);
    vecs[0] = '{1'b0, 9'd5,     9'd4, -1, 0, 1'b0, 14};  // basic
    vecs[1] = '{1'b0, 9'd5,     9'd4,  1, 5, 1'b0, 19};  // back-pressure on word 2
    vecs[2] = '{1'b0, 9'h1FE,   9'd3, -1, 0, 1'b0, 11};  // wrap-around
    vecs[3] = '{1'b0, 9'd9,     9'd0, -1, 0, 1'b0,  2};  // zero count
    vecs[4] = '{1'b0, 9'd5,     9'd4, -1, 0, 1'b1, 14};  // start while busy
    vecs[5] = '{1'b1, 9'd20,    9'd2, -1, 0, 1'b0, 12};  // RD_LAT=3

    #12;
    chk("rst_busy1",  int'(b1.busy), 0);
    chk("rst_valid1", int'(b1.dout_valid), 0);
    chk("rst_strobe1", int'(b1.dram_read_ext), 0);
    chk("rst_done3",  int'(b3.done), 0);
    chk("rst_addr3",  int'(b3.addr_ext), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 6; i++)
      run_dump(vecs[i].s, vecs[i].bs, vecs[i].n, vecs[i].sw, vecs[i].sl,
               vecs[i].poke, 1'b0, vecs[i].exp_cyc);

    // Reset during WAIT of word 2
    sel = 1'b0; base = 9'd5; cnt = 9'd4; ready = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    ns = 0; guard = 0;
    while (ns < 2 && guard < 30) begin
      if (m_strobe) ns++;
      if (ns < 2) begin
        @(negedge clock);
        guard++;
      end
    end
    chk("reset_reach_word2", ns, 2);
    @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_addr",   int'(b1.addr_ext), 0);
    chk("arst_strobe", int'(b1.dram_read_ext), 0);
    chk("arst_dout",   int'(b1.dout), 0);
    chk("arst_valid",  int'(b1.dout_valid), 0);
    chk("arst_busy",   int'(b1.busy), 0);
    chk("arst_done",   int'(b1.done), 0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    run_dump(1'b0, 9'd0, 9'd2, -1, 0, 1'b0, 1'b0, 8);

    // Randomized dumps with random ready
    for (int r = 0; r < 24; r++)
      run_dump(1'($urandom_range(0, 1)), 9'($urandom_range(0, 511)),
               9'($urandom_range(0, 5)), -1, 0, 1'b0, 1'b1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
